// File: rtl/store_data_formatter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_data_formatter_pkg
//  Description : Shared store-side opcodes, FSM state encoding and
//                big-endian byte-enable constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_data_formatter_pkg;

    // Shared EXE-stage operation codes for the store instructions
    localparam logic [7:0] EXE_SB_OP = 8'h28;
    localparam logic [7:0] EXE_SH_OP = 8'h29;
    localparam logic [7:0] EXE_SW_OP = 8'h2B;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] c_ST_RESP     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = c_ST_IDLE,
        ST_WAIT_ACK = c_ST_WAIT_ACK,
        ST_RESP     = c_ST_RESP
    } state_t;

    // Byte enables, big-endian: bit 3 selects data[31:24] (byte offset 0)
    localparam logic [3:0] c_WE_NONE = 4'b0000;
    localparam logic [3:0] c_WE_B0   = 4'b1000;
    localparam logic [3:0] c_WE_B1   = 4'b0100;
    localparam logic [3:0] c_WE_B2   = 4'b0010;
    localparam logic [3:0] c_WE_B3   = 4'b0001;
    localparam logic [3:0] c_WE_H0   = 4'b1100;
    localparam logic [3:0] c_WE_H1   = 4'b0011;
    localparam logic [3:0] c_WE_W    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/store_lane_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_encoder
//  Description : Combinational lane map for SB/SH/SW: byte enables,
//                lane-replicated write data and misalignment detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_encoder
    import store_data_formatter_pkg::*;
(
    input  logic [7:0]  alu_control,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Decode the store size and map it onto the big-endian byte lanes
    always_comb begin
        we         = c_WE_NONE;
        wdata      = 32'd0;
        misaligned = 1'b0;
        case (alu_control)
            EXE_SB_OP: begin
                wdata = {4{store_data[7:0]}};
                case (addr_lo)
                    2'b00:   we = c_WE_B0;
                    2'b01:   we = c_WE_B1;
                    2'b10:   we = c_WE_B2;
                    default: we = c_WE_B3;
                endcase
            end
            EXE_SH_OP: begin
                wdata = {2{store_data[15:0]}};
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    we = addr_lo[1] ? c_WE_H1 : c_WE_H0;
                end
            end
            EXE_SW_OP: begin
                wdata = store_data;
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    we = c_WE_W;
                end
            end
            default: begin
                we = c_WE_NONE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_data_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : store_data_formatter
//  Description : Accepts one store from MEM, checks alignment, formats byte
//                enables/data and runs a single-outstanding req/ack write to
//                data memory with an acknowledge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_data_formatter
    import store_data_formatter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  alu_control,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] bad_vaddr,
    output logic        stall
);

    localparam int               c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_mem_req;
    logic [3:0]           r_mem_we;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [31:0]          r_addr;
    logic [31:0]          r_bad_vaddr;
    logic                 r_addr_err;
    logic                 r_bus_err;

    logic [3:0]           w_enc_we;
    logic [31:0]          w_enc_wdata;
    logic                 w_enc_mis;
    logic                 w_accept;
    logic                 w_go_mem;
    logic                 w_ack;
    logic                 w_timeout;

    store_lane_encoder u_lane_enc (
        .alu_control (alu_control),
        .addr_lo     (addr[1:0]),
        .store_data  (store_data),
        .we          (w_enc_we),
        .wdata       (w_enc_wdata),
        .misaligned  (w_enc_mis)
    );

    // An aligned store is the only request that produces non-zero enables
    assign w_accept  = req_valid & req_ready;
    assign w_go_mem  = (w_enc_we != c_WE_NONE);
    assign w_ack     = (r_state == ST_WAIT_ACK) & r_mem_req & mem_ack;
    assign w_timeout = (r_state == ST_WAIT_ACK) & ~mem_ack & (r_cnt == c_CNT_LAST);

    assign req_ready = (r_state == ST_IDLE) & ~rst;
    assign stall     = (r_state != ST_IDLE);
    assign done      = (r_state == ST_RESP);
    assign addr_err  = done & r_addr_err;
    assign bus_err   = done & r_bus_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bad_vaddr = r_bad_vaddr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ack takes priority over a coincident timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_go_mem ? ST_WAIT_ACK : ST_RESP;
                end
            end
            ST_WAIT_ACK: begin
                if (w_ack || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Memory-port registers, timeout counter and error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= c_WE_NONE;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_addr      <= 32'd0;
            r_bad_vaddr <= 32'd0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= addr;
                r_addr_err <= w_enc_mis;
                r_bus_err  <= 1'b0;
                if (w_enc_mis) begin
                    r_bad_vaddr <= addr;
                end
                if (w_go_mem) begin
                    r_cnt       <= '0;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= w_enc_we;
                    r_mem_addr  <= {addr[31:2], 2'b00};
                    r_mem_wdata <= w_enc_wdata;
                end
            end else if (r_state == ST_WAIT_ACK) begin
                if (w_ack) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= c_WE_NONE;
                end else if (w_timeout) begin
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= c_WE_NONE;
                    r_bus_err   <= 1'b1;
                    r_bad_vaddr <= r_addr;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_data_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_data_formatter
//  Description : Self-checking bench: directed scenarios plus randomized
//                stores checked against a behavioural byte-lane model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_data_formatter;
    import store_data_formatter_pkg::*;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  alu_control;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        done;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] bad_vaddr;
    logic        stall;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_done = 0;
    int          n_acc  = 0;
    logic [31:0] exp_bad = 32'd0;

    store_data_formatter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .alu_control (alu_control),
        .addr        (addr),
        .store_data  (store_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .done        (done),
        .addr_err    (addr_err),
        .bus_err     (bus_err),
        .bad_vaddr   (bad_vaddr),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    // Count done pulses and accepted requests mid-cycle
    always @(negedge clk) begin
        if (done) n_done++;
        if (req_valid && req_ready) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: size from opcode, alignment by modulo, big-endian lanes
    function automatic void model(input logic [7:0] op, input logic [31:0] a,
                                  input logic [31:0] d, output bit is_store,
                                  output bit mis, output logic [3:0] we,
                                  output logic [31:0] wd);
        int size;
        int off;
        size = (op == EXE_SB_OP) ? 1 : (op == EXE_SH_OP) ? 2 : (op == EXE_SW_OP) ? 4 : 0;
        off  = int'(a[1:0]);
        is_store = (size != 0);
        mis  = is_store && ((off % size) != 0);
        we   = 4'd0;
        wd   = 32'd0;
        if (is_store && !mis) begin
            for (int b = 0; b < size; b++) we[3 - off - b] = 1'b1;
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % size) +: 8];
        end
    endfunction

    // One request; ack_dly = wait cycles before ack (<0 = never).
    // keep: present the next request straight after acceptance.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int ack_dly, input bit keep,
                           input logic [7:0] nop, input logic [31:0] na, input logic [31:0] nd);
        bit          is_st;
        bit          mis;
        bit          tmo;
        logic [3:0]  we;
        logic [31:0] wd;
        int          w;
        model(op, a, d, is_st, mis, we, wd);
        req_valid   = 1'b1;
        alu_control = op;
        addr        = a;
        store_data  = d;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            chk("ready_wait", {31'd0, req_ready}, 32'd1);
            return;
        end
        @(posedge clk); #1;
        if (keep) begin
            alu_control = nop;
            addr        = na;
            store_data  = nd;
        end else begin
            req_valid   = 1'b0;
            alu_control = 8'($urandom);
            addr        = $urandom;
            store_data  = $urandom;
        end
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        chk("stall_busy", {31'd0, stall}, 32'd1);
        if (!is_st || mis) begin
            mem_ack = 1'b1;
            if (mis) exp_bad = a;
            chk("done_short",  {31'd0, done},     32'd1);
            chk("addr_err",    {31'd0, addr_err}, {31'd0, mis});
            chk("bus_err_s",   {31'd0, bus_err},  32'd0);
            chk("no_mem_req",  {31'd0, mem_req},  32'd0);
            chk("no_mem_we",   {28'd0, mem_we},   32'd0);
            chk("bad_vaddr_s", bad_vaddr, exp_bad);
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end else begin
            tmo = (ack_dly < 0) || (ack_dly >= TO);
            for (int k = 0; k < TO; k++) begin
                chk("mem_req",   {31'd0, mem_req}, 32'd1);
                chk("mem_we",    {28'd0, mem_we},  {28'd0, we});
                chk("mem_wdata", mem_wdata, wd);
                chk("mem_addr",  mem_addr, {a[31:2], 2'b00});
                chk("done_wait", {31'd0, done},  32'd0);
                chk("stall",     {31'd0, stall}, 32'd1);
                if (k == ack_dly) begin
                    mem_ack = 1'b1;
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                    break;
                end
                @(posedge clk); #1;
            end
            if (tmo) exp_bad = a;
            chk("done",        {31'd0, done},     32'd1);
            chk("bus_err",     {31'd0, bus_err},  {31'd0, tmo});
            chk("addr_err_m",  {31'd0, addr_err}, 32'd0);
            chk("req_dropped", {31'd0, mem_req},  32'd0);
            chk("we_cleared",  {28'd0, mem_we},   32'd0);
            chk("bad_vaddr",   bad_vaddr, exp_bad);
            @(posedge clk); #1;
        end
        chk("done_once",  {31'd0, done},      32'd0);
        chk("stall_idle", {31'd0, stall},     32'd0);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int d0;
        int a0;
        logic [7:0]  op;
        logic [31:0] ra;
        rst = 1'b1; req_valid = 1'b0; alu_control = 8'd0; addr = 32'd0;
        store_data = 32'd0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {28'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_wdata",     mem_wdata, 32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_bad_vaddr", bad_vaddr, 32'd0);
        chk("rst_ready",     {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_txn(EXE_SB_OP, 32'h0000_1003, 32'hAABB_CC5A, 0, 1'b0, 8'd0, 32'd0, 32'd0);
        run_txn(EXE_SH_OP, 32'h0000_2002, 32'h0000_BEEF, 4, 1'b0, 8'd0, 32'd0, 32'd0);
        run_txn(EXE_SW_OP, 32'h0000_3001, 32'h1234_5678, 0, 1'b0, 8'd0, 32'd0, 32'd0);
        run_txn(EXE_SW_OP, 32'h0000_4000, 32'hCAFE_F00D, -1, 1'b0, 8'd0, 32'd0, 32'd0);
        run_txn(EXE_SW_OP, 32'h0000_4000, 32'hCAFE_F00D, TO-1, 1'b0, 8'd0, 32'd0, 32'd0);
        run_txn(8'h01,     32'h0000_5003, 32'h0BAD_0BAD, 0, 1'b0, 8'd0, 32'd0, 32'd0);

        // Reset while waiting for ack
        req_valid = 1'b1; alu_control = EXE_SW_OP; addr = 32'h0000_6000; store_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        d0 = n_done;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_bad = 32'd0;
        chk("mrst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("mrst_mem_we",   {28'd0, mem_we},   32'd0);
        chk("mrst_addr",     mem_addr, 32'd0);
        chk("mrst_wdata",    mem_wdata, 32'd0);
        chk("mrst_bad",      bad_vaddr, 32'd0);
        chk("mrst_stall",    {31'd0, stall},    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_no_done", n_done, d0);
        run_txn(EXE_SB_OP, 32'h0000_7001, 32'h0000_0077, 1, 1'b0, 8'd0, 32'd0, 32'd0);

        // Back-to-back with req_valid held high
        d0 = n_done; a0 = n_acc;
        run_txn(EXE_SW_OP, 32'h0000_8000, 32'h1111_1111, 0, 1'b1, EXE_SH_OP, 32'h0000_8102, 32'h0000_2222);
        run_txn(EXE_SH_OP, 32'h0000_8102, 32'h0000_2222, 2, 1'b1, EXE_SB_OP, 32'h0000_8201, 32'h0000_0033);
        run_txn(EXE_SB_OP, 32'h0000_8201, 32'h0000_0033, 0, 1'b0, 8'd0, 32'd0, 32'd0);
        chk("b2b_done_cnt", n_done - d0, 32'd3);
        chk("b2b_acc_cnt",  n_acc - a0,  32'd3);

        // Randomized stores
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: op = EXE_SB_OP;
                1: op = EXE_SH_OP;
                2: op = EXE_SW_OP;
                3: op = EXE_SW_OP;
                default: op = 8'h01;
            endcase
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) ra[1] = 1'b0;
            run_txn(op, ra, $urandom, int'($urandom_range(0, TO + 1)), 1'b0, 8'd0, 32'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_data_formatter.md
Name: store_data_formatter

Overview:
Store-side counterpart of the load-data extractor. It accepts one store (SB/SH/SW) from the EXE/MEM stage, checks alignment, and builds the big-endian byte-enable mask and replicated write data. It then drives a single-outstanding request/acknowledge transaction to data memory, with an acknowledge timeout. It sits between the MEM stage and the data-memory port and stalls the pipeline while a store is in flight.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for mem_ack after issuing before aborting with bus_err (must be at least 1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  store request present
req_ready  output  1  block can accept a request; high only in IDLE and not in reset
alu_control  input  8  operation code; uses the shared EXE_SB_OP, EXE_SH_OP and EXE_SW_OP codes
addr  input  32  byte address of the store
store_data  input  32  register value to store; low bits carry the byte/halfword
mem_req  output  1  memory write request
mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
mem_we  output  4  byte enables; bit3 selects data[31:24]
mem_wdata  output  32  lane-replicated write data
mem_ack  input  1  memory accepted the write
done  output  1  one-cycle completion pulse
addr_err  output  1  one-cycle pulse together with done: misaligned store, no memory access
bus_err  output  1  one-cycle pulse together with done: ack timeout
bad_vaddr  output  32  address of the last errored store; held until the next error
stall  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_we=0, mem_wdata=0, mem_addr=0, done=0, addr_err=0, bus_err=0, bad_vaddr=0, counter=0. Reset mid-transaction drops mem_req at that edge, and no done is produced.
- Handshake: a request is accepted on a cycle where req_valid and req_ready are both high; all inputs are captured at that edge.
- Lane map (big-endian, mirrors the load side):
  - SB: addr[1:0] 00/01/10/11 gives we 1000/0100/0010/0001; wdata={4{store_data[7:0]}}.
  - SH: 00 gives 1100 and 10 gives 0011; wdata={2{store_data[15:0]}}.
  - SW: 00 gives 1111; wdata=store_data.
- Misaligned: SH with addr[0]=1, or SW with addr[1:0]!=00. Outcome: no mem_req; next cycle done=1, addr_err=1, bad_vaddr=addr.
- Non-store alu_control is accepted and completes with done next cycle, with no memory access and no error.
- FSM states: IDLE, WAIT_ACK, RESP.
  - IDLE to WAIT_ACK on accepting an aligned store. mem_req, mem_we, mem_addr and mem_wdata are registered and valid from T+1.
  - IDLE to RESP on accepting a misaligned or non-store request.
  - WAIT_ACK: outputs are held stable. When mem_ack is sampled high, go to RESP, deassert mem_req and clear mem_we at the same edge.
  - WAIT_ACK: the counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES-1 without ack, go to RESP with bus_err, drop mem_req, and set bad_vaddr=captured addr.
  - RESP: done=1 for exactly one cycle (plus addr_err or bus_err if applicable), then IDLE. req_ready rises in the cycle after RESP.
- Latency: zero-wait memory (ack at T+1) gives done at T+2. Throughput is one store per 3 cycles minimum.
- Simultaneous events:
  - mem_ack on the timeout cycle: ack wins, no bus_err.
  - mem_ack while mem_req=0 is ignored.
  - req_valid outside IDLE is not accepted; the requester holds it.
- mem_we=0 whenever mem_req=0.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to WAIT_ACK.

Decomposition:
- Shared defines header (existing): the EXE_SB_OP, EXE_SH_OP and EXE_SW_OP opcodes.
- Add to the shared package: the state encoding constants (IDLE/WAIT_ACK/RESP) and the byte-enable constants.
- One combinational sub-module, store_lane_encoder (alu_control, addr[1:0], store_data to we, wdata, misaligned), pairs naturally with the load-side extractor. FSM, counter and registers stay in the top module.

Test Plan:
- SB to addr 0x1003, data 0xAABBCC5A, ack at T+1 -> mem_we=0001, mem_wdata=0x5A5A5A5A, mem_addr=0x1000, done at T+2, no errors.
- SH to 0x2002, data 0x0000BEEF, ack after 5 cycles -> mem_we=0011, wdata=0xBEEFBEEF held stable all 5 cycles, stall high throughout, single done.
- SW to 0x3001 -> no mem_req ever; done+addr_err at T+1; bad_vaddr=0x3001.
- TIMEOUT_CYCLES=4, SW to 0x4000, ack never -> mem_req high 4 cycles then low; done+bus_err pulse; bad_vaddr=0x4000. Repeat with ack on the last cycle -> no bus_err.
- rst asserted while in WAIT_ACK -> next edge: mem_req=0, all outputs at reset values, no done; a following SB completes normally.
- Back-to-back req_valid held high with 3 stores -> each accepted only in IDLE, 3 done pulses, no request lost or duplicated.
